// File: rtl/clk_sched_pkg.sv
// Shared types and helpers for the clock-enable scheduler.
package clk_sched_pkg;

    typedef enum logic [1:0] {WARMUP, RUN, HOLD} state_e;

    localparam int MIN_DIV = 2;

    // Length of the high phase; odd divisors put the extra cycle in the low phase.
    function automatic logic [31:0] half_period(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_period_gen.sv
// Period counter with high/low compare and tick; outputs are registered from
// next-cycle counter values so pins line up with the counter register.
module clk_period_gen
    import clk_sched_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] n,
    output logic             wrap,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             run_q;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    always_comb begin
        wrap      = run_q && (cnt_q == n_q - CNT_W'(1));
        n_d       = load ? n : n_q;
        cnt_d     = '0;
        // Entering RUN, leaving RUN, or wrapping all restart the period at 0.
        if (run && run_q && !wrap) cnt_d = cnt_q + CNT_W'(1);
        clk_out_d = run && (cnt_d < CNT_W'(half_period(32'(n_d))));
        tick_d    = run && (cnt_d == '0);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            n_q       <= CNT_W'(DEFAULT_DIV);
            run_q     <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            run_q     <= run;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_sched.sv
// Clock-enable scheduler top: warm-up/run/hold FSM, divisor change handshake,
// sticky error flag. Period shaping lives in clk_period_gen.
module clk_div_sched
    import clk_sched_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int DEFAULT_DIV   = 2,
    parameter int WARMUP_CYCLES = 1024
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             busy,
    output logic             clk_out,
    output logic             tick,
    output logic             locked,
    output logic             err
);

    localparam int WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [WU_W-1:0]  wu_q, wu_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;
    logic             wrap, apply, run;

    always_comb begin
        state_d = state_q;
        wu_d    = wu_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        err_d   = err_q;

        unique case (state_q)
            WARMUP: begin
                wu_d = wu_q + WU_W'(1);
                if (wu_q == WU_W'(WARMUP_CYCLES - 1)) begin
                    state_d = en ? RUN : HOLD;
                    wu_d    = '0;
                end
            end
            RUN:     if (wrap && !en) state_d = HOLD;
            HOLD:    if (en) state_d = RUN;
            default: state_d = WARMUP;
        endcase

        // Changeover only at a period boundary while running; anywhere else at once.
        apply = busy_q && (state_q != RUN || wrap);
        if (apply) busy_d = 1'b0;

        // busy_q (not busy_d) gates capture, so a request landing on the apply
        // cycle is dropped and one landing on a wrap waits for the next boundary.
        if (div_req && !busy_q) begin
            busy_d = 1'b1;
            if (div_val < CNT_W'(MIN_DIV)) begin
                pend_d = CNT_W'(MIN_DIV);
                err_d  = 1'b1;
            end else begin
                pend_d = div_val;
            end
        end

        ack_d    = apply;
        run      = (state_d == RUN);
        locked_d = run;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= WARMUP;
            wu_q     <= '0;
            pend_q   <= CNT_W'(DEFAULT_DIV);
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wu_q     <= wu_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    clk_period_gen #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_gen (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .run     (run),
        .load    (apply),
        .n       (pend_q),
        .wrap    (wrap),
        .clk_out (clk_out),
        .tick    (tick)
    );

    assign div_ack = ack_q;
    assign busy    = busy_q;
    assign locked  = locked_q;
    assign err     = err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: scripted scenarios plus random traffic, every cycle
// compared against a period/position reference model.
module tb_clk_div_sched;

    localparam int CNT_W = 8;
    localparam int DEF   = 2;
    localparam int WU    = 8;

    logic             clk_in  = 1'b0;
    logic             rst_n   = 1'b0;
    logic             en      = 1'b0;
    logic             div_req = 1'b0;
    logic [CNT_W-1:0] div_val = '0;
    logic             div_ack, busy, clk_out, tick, locked, err;

    int n_chk = 0;
    int n_err = 0;
    int ack_seen = 0;

    // Reference model: mode 0 = warming, 1 = running, 2 = holding.
    int m_mode, m_warm, m_pos, m_n;
    int m_pend[$];
    bit m_ack, m_err;

    clk_div_sched #(
        .CNT_W         (CNT_W),
        .DEFAULT_DIV   (DEF),
        .WARMUP_CYCLES (WU)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .busy    (busy),
        .clk_out (clk_out),
        .tick    (tick),
        .locked  (locked),
        .err     (err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit q, input int v);
        bit bnd, app, cap;
        if (!r) begin
            m_mode = 0; m_warm = WU; m_pos = 0; m_n = DEF;
            m_pend.delete(); m_ack = 0; m_err = 0;
            return;
        end
        bnd = (m_mode == 1) && (m_pos == m_n - 1);
        app = (m_pend.size() != 0) && (m_mode != 1 || bnd);
        cap = q && (m_pend.size() == 0);
        case (m_mode)
            0: begin
                m_warm--;
                if (m_warm == 0) begin m_mode = e ? 1 : 2; m_pos = 0; end
            end
            1: if (bnd && !e) begin m_mode = 2; m_pos = 0; end
               else m_pos = bnd ? 0 : m_pos + 1;
            default: if (e) begin m_mode = 1; m_pos = 0; end
        endcase
        m_ack = app;
        if (app) m_n = m_pend.pop_front();
        if (cap) begin
            m_pend.push_back(v < 2 ? 2 : v);
            if (v < 2) m_err = 1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare all pins.
    task automatic step(input bit r, input bit e, input bit q, input int v);
        rst_n = r; en = e; div_req = q; div_val = CNT_W'(v);
        model(r, e, q, v);
        @(negedge clk_in);
        if (div_ack === 1'b1) ack_seen++;
        chk("clk_out", clk_out, (m_mode == 1) && (m_pos < m_n / 2));
        chk("tick",    tick,    (m_mode == 1) && (m_pos == 0));
        chk("locked",  locked,  m_mode == 1);
        chk("busy",    busy,    m_pend.size() != 0);
        chk("div_ack", div_ack, m_ack);
        chk("err",     err,     m_err);
    endtask

    // Run until the model sits at a given period position with nothing pending
    // (p < 0 selects the last position of the period).
    task automatic seek(input string tag, input int p);
        int i = 0;
        while (i < 600 && !(m_mode == 1 && m_pos == (p < 0 ? m_n - 1 : p)
                            && m_pend.size() == 0)) begin
            step(1, 1, 0, 0);
            i++;
        end
        chk(tag, i < 600, 1'b1);
    endtask

    initial begin
        bit r, e, q;
        int v;
        @(negedge clk_in);

        // Reset, warm-up, then default divide-by-2.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        repeat (20) step(1, 1, 0, 0);

        // Mid-period change from 2 to 5.
        seek("seek_n2_pos1", 1);
        ack_seen = 0;
        step(1, 1, 1, 5);
        chk("busy_after_req5", busy, 1'b1);
        repeat (20) step(1, 1, 0, 0);
        chk("ack_count_5", ack_seen, 1);

        // Out-of-range request: clamped, flagged, still acked.
        ack_seen = 0;
        step(1, 1, 1, 1);
        repeat (12) step(1, 1, 0, 0);
        chk("err_sticky", err, 1'b1);
        chk("ack_count_clamp", ack_seen, 1);

        // Second request while busy is dropped.
        ack_seen = 0;
        step(1, 1, 1, 4);
        step(1, 1, 1, 7);
        repeat (20) step(1, 1, 0, 0);
        chk("ack_count_busy", ack_seen, 1);

        // en dropped at cnt=1 of an N=6 period, then restarted.
        step(1, 1, 1, 6);
        repeat (16) step(1, 1, 0, 0);
        seek("seek_n6_pos1", 1);
        repeat (12) step(1, 0, 0, 0);
        chk("hold_unlocked", locked, 1'b0);
        repeat (10) step(1, 1, 0, 0);

        // Request landing exactly on a wrap boundary.
        seek("seek_wrap", -1);
        step(1, 1, 1, 3);
        repeat (12) step(1, 1, 0, 0);

        // Reset while a request is pending at N=9.
        step(1, 1, 1, 9);
        repeat (20) step(1, 1, 0, 0);
        step(1, 1, 1, 4);
        chk("busy_before_rst", busy, 1'b1);
        ack_seen = 0;
        step(0, 1, 0, 0);
        repeat (30) step(1, 1, 0, 0);
        chk("no_ack_after_rst", ack_seen, 0);

        // Largest divisor.
        step(1, 1, 1, 255);
        repeat (540) step(1, 1, 0, 0);

        // Random traffic.
        repeat (1500) begin
            r = ($urandom_range(199) != 0);
            e = ($urandom_range(15) != 0);
            q = ($urandom_range(9) == 0);
            v = $urandom_range(12);
            if (m_pend.size() != 0 && v < 2) v = v + 2;
            step(r, e, q, v);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
